serial_loader: RTL and testbench
================================

SERIAL_LOADER -- requirements
Module: serial_loader

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 208, meaning clk cycles per UART bit (24 MHz / 115200).
REQ-002 The block SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-003 The block SHALL have port RESET_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port RxPin  input  1  UART receive line, 8N1, LSB first, idle high.
REQ-005 The block SHALL have port WrAddress  output  11  RAM write address.
REQ-006 The block SHALL have port WrData  output  8  RAM write data.
REQ-007 The block SHALL have port WrEn  output  1  one-cycle RAM write strobe.
REQ-008 The block SHALL have port Busy  output  1  high while a record is open (parser not IDLE).
REQ-009 The block SHALL have port Err  output  1  one-cycle pulse on a framing error or a protocol error.

Function
REQ-010 RxPin SHALL pass through a 2-flop synchronizer before any use.
REQ-011 Receiver start: on a synchronized 1->0 edge, wait BAUD_DIV/2 cycles and resample; if high, abort silently and return to idle.
REQ-012 Receiver data bits: sample 8 data bits at BAUD_DIV intervals from the start midpoint, LSB first.
REQ-013 Receiver stop bit: sample the stop bit; if 1, raise internal rx_valid for 1 cycle with the byte; if 0, discard the byte, pulse Err, and wait for the line to go high before re-arming.
REQ-014 The parser FSM SHALL have states IDLE, ADDR, HASH, DATA_HI, DATA_LO and SHALL act only on rx_valid.
REQ-015 IDLE: '$' -> ADDR with digit count cleared; all other bytes ignored, no Err.
REQ-016 ADDR: collect 4 hex digits MSB first into a 16-bit shift register; after the 4th digit -> HASH.
REQ-017 HASH: '#' -> DATA_HI and load the write pointer from bits [10:0] of the shift register; bits [15:11] are discarded.
REQ-018 DATA_HI: hex digit -> latch the high nibble and go to DATA_LO; ' ' is ignored; CR (0x0D) -> IDLE.
REQ-019 DATA_LO: hex digit -> form the byte and go to DATA_HI.
REQ-020 Write timing: the cycle after the DATA_LO rx_valid, WrEn=1, WrData=byte, WrAddress=pointer.
REQ-021 Pointer update: the pointer SHALL increment in the cycle after WrEn and wrap 0x7FF->0x000.
REQ-022 Hex digits are '0'-'9' and 'A'-'F' only (see REQ-029).
REQ-023 '$' in any non-IDLE state SHALL restart at ADDR with no Err; a partial byte is dropped.
REQ-024 Any other unexpected byte in ADDR, HASH, DATA_HI or DATA_LO -> IDLE with a 1-cycle Err; no write.
REQ-025 A framing error while not IDLE SHALL also force IDLE.
REQ-026 Busy SHALL be high in every state except IDLE.
REQ-027 A byte completing during WrEn SHALL be handled normally; no byte is ever lost, since min byte spacing is 10*BAUD_DIV cycles.

Reset
REQ-028 While RESET_n=0: receiver idle; parser IDLE; WrAddress=0; WrData=0; WrEn=0; Busy=0; Err=0; synchronizer flops=1. An asserted reset aborts any byte or record in progress, and no write occurs after release until a new '$'.

Configuration
REQ-029 Macro SERIAL_LOADER_LOWERCASE_EN: if defined, 'a'-'f' SHALL also be accepted as hex digits in ADDR, DATA_HI and DATA_LO; if undefined, 'a'-'f' is a protocol error per REQ-024.

Verification
REQ-030 Send "$0030#AA BB\r" -> WrEn twice: (0x030,0xAA), then (0x031,0xBB); Busy falls after CR; Err never pulses.
REQ-031 Send "$07FF#11 22\r" -> writes (0x7FF,0x11) then (0x000,0x22).
REQ-032 Send 0x41 with stop bit 0, then "$0001#5A\r" -> one Err pulse, then a single write (0x001,0x5A).
REQ-033 Send "$00G0#12\r" -> Err at 'G', Busy low, no WrEn for the whole string.
REQ-034 Send "$0100#1$0200#34\r" -> single write (0x200,0x34), no Err.
REQ-035 Send "$0000#ab\r": with the macro -> write (0x000,0xAB); without it -> Err, no write. Also assert RESET_n low mid-byte -> all outputs 0, then a clean resend of the string behaves per the macro.

Source files
------------

// File: rtl/serial_loader.sv
// serial_loader: UART (8N1) receiver feeding a "$AAAA#DD DD\r" hex-record parser that writes bytes to RAM.
// Define SERIAL_LOADER_LOWERCASE_EN to also accept 'a'-'f' as hex digits.
module serial_loader #(
    parameter int BAUD_DIV = 208
) (
    input  logic        clk,
    input  logic        RESET_n,
    input  logic        RxPin,
    output logic [10:0] WrAddress,
    output logic [7:0]  WrData,
    output logic        WrEn,
    output logic        Busy,
    output logic        Err
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;
    typedef enum logic [2:0] {P_IDLE, P_ADDR, P_HASH, P_HI, P_LO} p_state_t;

    rx_state_t rx_state, rx_next;
    p_state_t p_state, p_next;
    logic sync1, sync2, prev;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] rx_byte;
    logic tick_half, tick_full, rx_valid, frame_err;
    logic is_dec, is_uc, is_lc, hex_ok, proto_err, wr_go;
    logic [3:0] nib, hi_nib;
    logic [1:0] digits;
    logic [10:0] addr_sh, ptr;

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) {sync1, sync2, prev} <= 3'b111;
        else {sync1, sync2, prev} <= {RxPin, sync1, sync2};
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) rx_state <= R_IDLE;
        else rx_state <= rx_next;
    end

    always_comb begin
        tick_half = cnt == HALF;
        tick_full = cnt == FULL;
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:  rx_next = (prev && !sync2) ? R_START : R_IDLE;
            R_START: rx_next = !tick_half ? R_START : (sync2 ? R_IDLE : R_DATA);
            R_DATA:  rx_next = (tick_full && bit_idx == 3'd7) ? R_STOP : R_DATA;
            R_STOP:  rx_next = !tick_full ? R_STOP : (sync2 ? R_IDLE : R_WAIT);
            R_WAIT:  rx_next = sync2 ? R_IDLE : R_WAIT;
            default: rx_next = R_IDLE;
        endcase
    end

    always_comb begin
        rx_valid = rx_state == R_STOP && tick_full && sync2;
        frame_err = rx_state == R_STOP && tick_full && !sync2;
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            cnt <= '0;
            bit_idx <= '0;
            rx_byte <= '0;
        end else begin
            cnt <= (rx_next != rx_state || tick_full) ? '0 : cnt + 1'b1;
            if (rx_state == R_START) bit_idx <= '0;
            if (rx_state == R_DATA && tick_full) begin
                bit_idx <= bit_idx + 1'b1;
                rx_byte <= {sync2, rx_byte[7:1]};
            end
        end
    end

    always_comb begin
        is_dec = rx_byte >= "0" && rx_byte <= "9";
        is_uc = rx_byte >= "A" && rx_byte <= "F";
`ifdef SERIAL_LOADER_LOWERCASE_EN
        is_lc = rx_byte >= "a" && rx_byte <= "f";
`else
        is_lc = 1'b0;
`endif
        hex_ok = is_dec | is_uc | is_lc;
        nib = is_dec ? rx_byte[3:0] : rx_byte[3:0] + 4'd9;
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) p_state <= P_IDLE;
        else p_state <= p_next;
    end

    always_comb begin
        p_next = p_state;
        proto_err = 1'b0;
        if (frame_err) p_next = P_IDLE;
        else if (rx_valid) begin
            if (rx_byte == "$") p_next = P_ADDR;
            else begin
                case (p_state)
                    P_ADDR:  p_next = !hex_ok ? P_IDLE : (digits == 2'd3 ? P_HASH : P_ADDR);
                    P_HASH:  p_next = rx_byte == "#" ? P_HI : P_IDLE;
                    P_HI:    p_next = hex_ok ? P_LO : (rx_byte == " " ? P_HI : P_IDLE);
                    P_LO:    p_next = hex_ok ? P_HI : P_IDLE;
                    default: p_next = P_IDLE;
                endcase
                // CR legitimately closes a record from DATA_HI; every other drop to IDLE is an error
                proto_err = p_state != P_IDLE && p_next == P_IDLE && !(p_state == P_HI && rx_byte == 8'h0D);
            end
        end
    end

    always_comb begin
        Busy = p_state != P_IDLE;
        wr_go = rx_valid && p_state == P_LO && hex_ok;
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            digits <= '0;
            addr_sh <= '0;
            ptr <= '0;
            hi_nib <= '0;
            WrEn <= 1'b0;
            WrData <= '0;
            WrAddress <= '0;
            Err <= 1'b0;
        end else begin
            WrEn <= wr_go;
            Err <= proto_err | frame_err;
            if (wr_go) begin
                WrData <= {hi_nib, nib};
                WrAddress <= ptr;
            end
            if (WrEn) ptr <= ptr + 1'b1;
            if (rx_valid) begin
                if (rx_byte == "$") digits <= '0;
                else if (p_state == P_ADDR && hex_ok) begin
                    digits <= digits + 1'b1;
                    addr_sh <= {addr_sh[6:0], nib};
                end
                if (p_state == P_HASH && rx_byte == "#") ptr <= addr_sh;
                if (p_state == P_HI && hex_ok) hi_nib <= nib;
            end
        end
    end
endmodule

// File: tb/tb_serial_loader.sv
// tb_serial_loader: directed and random UART records checked against a string-level reference parser.
module tb_serial_loader;
    localparam int BD = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic [10:0] wr_address;
    logic [7:0] wr_data;
    logic wr_en, busy, err;

    serial_loader #(.BAUD_DIV(BD)) dut (
        .clk(clk),
        .RESET_n(rst_n),
        .RxPin(rx),
        .WrAddress(wr_address),
        .WrData(wr_data),
        .WrEn(wr_en),
        .Busy(busy),
        .Err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [18:0] obs_q[$];
    logic [18:0] exp_q[$];
    int obs_err = 0;
    int exp_err = 0;
    int done = 0;
    // reference parser: 0 idle, 1 address digits, 2 expect '#', 3 high nibble, 4 low nibble
    int m_ph = 0, m_nd = 0, m_hi = 0, m_addr = 0, m_ptr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) obs_q.push_back({wr_address, wr_data});
            if (err) obs_err++;
        end
    end

    function automatic int hexv(input byte c);
        if (c >= "0" && c <= "9") return int'(c) - int'("0");
        if (c >= "A" && c <= "F") return int'(c) - int'("A") + 10;
`ifdef SERIAL_LOADER_LOWERCASE_EN
        if (c >= "a" && c <= "f") return int'(c) - int'("a") + 10;
`endif
        return -1;
    endfunction

    function automatic byte hexc(input int v, input bit lower);
        if (v < 10) return byte'(int'("0") + v);
        return byte'((lower ? int'("a") : int'("A")) + v - 10);
    endfunction

    task automatic model_byte(input byte c);
        int v;
        v = hexv(c);
        if (c == "$") begin
            m_ph = 1; m_nd = 0; m_addr = 0;
        end else if (m_ph == 0) begin
        end else if (m_ph == 1 && v >= 0) begin
            m_addr = m_addr * 16 + v;
            m_nd++;
            if (m_nd == 4) m_ph = 2;
        end else if (m_ph == 2 && c == "#") begin
            m_ptr = m_addr % 2048; m_ph = 3;
        end else if (m_ph == 3 && c == " ") begin
        end else if (m_ph == 3 && c == 8'h0D) begin
            m_ph = 0;
        end else if (m_ph == 3 && v >= 0) begin
            m_hi = v; m_ph = 4;
        end else if (m_ph == 4 && v >= 0) begin
            exp_q.push_back({11'(m_ptr), 8'(m_hi * 16 + v)});
            m_ptr = (m_ptr + 1) % 2048;
            m_ph = 3;
        end else begin
            exp_err++; m_ph = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        rx = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BD) @(negedge clk);
        end
        rx = stop;
        repeat (BD) @(negedge clk);
        rx = 1'b1;
        repeat ($urandom_range(2, 5)) @(negedge clk);
        if (stop) model_byte(b);
        else begin
            exp_err++; m_ph = 0;
        end
    endtask

    task automatic send_q(input byte q[$]);
        foreach (q[i]) send_byte(q[i], 1'b1);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic verify(input string tag);
        repeat (4) @(negedge clk);
        check({tag, "_nwr"}, obs_q.size(), exp_q.size());
        for (int i = done; i < exp_q.size() && i < obs_q.size(); i++) check({tag, "_wr"}, obs_q[i], exp_q[i]);
        done = exp_q.size() > obs_q.size() ? exp_q.size() : obs_q.size();
        check({tag, "_err"}, obs_err, exp_err);
        check({tag, "_busy"}, busy, m_ph != 0);
    endtask

    initial begin
        byte q[$];
        int n;
        repeat (3) @(negedge clk);
        check("rst_out", {busy, err, wr_en, wr_data, wr_address}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst", {busy, err, wr_en}, 0);

        send_str("$0030#AA BB\015");
        check("r30_first", obs_q.size() > 0 ? obs_q[0] : 19'h7FFFF, {11'h030, 8'hAA});
        verify("r30");
        send_str("$07FF#11 22\015");
        verify("r31");
        send_byte(8'h41, 1'b0);
        send_str("$0001#5A\015");
        verify("r32");
        send_str("$00");
        check("r33_open", busy, 1'b1);
        send_str("G0#12\015");
        verify("r33");
        send_str("$0100#1$0200#34\015");
        verify("r34");
        send_str("$0000#ab\015");
        verify("r35");

        send_str("$01");
        check("pre_abort_busy", busy, 1'b1);
        rx = 1'b0;
        repeat (BD * 3) @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("abort_out", {busy, err, wr_en, wr_data, wr_address}, 0);
        rx = 1'b1;
        m_ph = 0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_str("00#12\015");
        verify("abort_nowr");
        send_str("$0000#ab\015");
        verify("r35_resend");

        for (int r = 0; r < 16; r++) begin
            int a;
            q.delete();
            q.push_back("$");
            a = $urandom_range(0, 65535);
            for (int d = 3; d >= 0; d--) q.push_back(hexc((a >> (4 * d)) & 15, $urandom_range(0, 5) == 0));
            q.push_back("#");
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                int v;
                v = $urandom_range(0, 255);
                if ($urandom_range(0, 2) == 0) q.push_back(" ");
                q.push_back(hexc(v >> 4, $urandom_range(0, 5) == 0));
                q.push_back(hexc(v & 15, $urandom_range(0, 5) == 0));
            end
            q.push_back(8'h0D);
            if ($urandom_range(0, 3) == 0) begin
                byte bad[4];
                bad = '{"Z", "$", 8'h0D, "g"};
                q.insert($urandom_range(1, q.size() - 1), bad[$urandom_range(0, 3)]);
            end
            send_q(q);
            verify($sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
